// File: rtl/kbest_sorter.sv
// kbest_sorter: keeps the K smallest (distance, index) candidates of a framed
// query stream and presents the ascending list with a one-cycle valid pulse.
module kbest_sorter #(
    parameter int unsigned DIST_WIDTH = 25,
    parameter int unsigned IDX_WIDTH  = 9,
    parameter int unsigned K          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      query_valid,
    input  logic                      query_first_in,
    input  logic                      query_last_in,
    input  logic [DIST_WIDTH-1:0]     dist_in,
    input  logic [IDX_WIDTH-1:0]      idx_in,
    output logic                      valid_out,
    output logic [K*DIST_WIDTH-1:0]   sorted_dist,
    output logic [K*IDX_WIDTH-1:0]    sorted_idx,
    output logic                      query_open,
    output logic                      protocol_err
);

    localparam logic [DIST_WIDTH-1:0] DIST_MAX = '1;
    localparam logic [IDX_WIDTH-1:0]  IDX_NONE = '0;

    typedef enum logic [0:0] {IDLE, OPEN} state_t;

    state_t                state, state_nxt;
    logic [DIST_WIDTH-1:0] list_dist     [K];
    logic [IDX_WIDTH-1:0]  list_idx      [K];
    logic [DIST_WIDTH-1:0] list_dist_nxt [K];
    logic [IDX_WIDTH-1:0]  list_idx_nxt  [K];
    logic [DIST_WIDTH-1:0] ins_dist      [K];
    logic [IDX_WIDTH-1:0]  ins_idx       [K];
    logic [DIST_WIDTH-1:0] load_dist     [K];
    logic [IDX_WIDTH-1:0]  load_idx      [K];
    logic [K-1:0]          le;
    logic                  emit_nxt;
    logic                  err_nxt;

    // Parallel compare-and-shift insertion plus the fresh-query load image.
    // le is a thermometer code because the list is kept sorted; the candidate
    // lands at the first entry that is strictly greater, after any equal ones.
    always_comb begin
        for (int i = 0; i < int'(K); i++) begin
            le[i]        = (list_dist[i] <= dist_in);
            load_dist[i] = DIST_MAX;
            load_idx[i]  = IDX_NONE;
        end
        load_dist[0] = dist_in;
        load_idx[0]  = idx_in;

        ins_dist[0] = le[0] ? list_dist[0] : dist_in;
        ins_idx[0]  = le[0] ? list_idx[0]  : idx_in;
        for (int i = 1; i < int'(K); i++) begin
            if (le[i]) begin
                ins_dist[i] = list_dist[i];
                ins_idx[i]  = list_idx[i];
            end else if (le[i-1]) begin
                ins_dist[i] = dist_in;
                ins_idx[i]  = idx_in;
            end else begin
                ins_dist[i] = list_dist[i-1];
                ins_idx[i]  = list_idx[i-1];
            end
        end
    end

    // Next-state, next working list, emit and protocol-error decisions.
    always_comb begin
        state_nxt     = state;
        list_dist_nxt = list_dist;
        list_idx_nxt  = list_idx;
        emit_nxt      = 1'b0;
        err_nxt       = protocol_err;
        if (query_valid) begin
            if (query_first_in) begin
                if (state == OPEN) err_nxt = 1'b1;
                list_dist_nxt = load_dist;
                list_idx_nxt  = load_idx;
                if (query_last_in) begin
                    emit_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = OPEN;
                end
            end else if (state == IDLE) begin
                err_nxt = 1'b1;
            end else begin
                list_dist_nxt = ins_dist;
                list_idx_nxt  = ins_idx;
                if (query_last_in) begin
                    emit_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    // State, working list and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            protocol_err <= 1'b0;
            for (int i = 0; i < int'(K); i++) begin
                list_dist[i] <= DIST_MAX;
                list_idx[i]  <= IDX_NONE;
            end
        end else begin
            state        <= state_nxt;
            protocol_err <= err_nxt;
            list_dist    <= list_dist_nxt;
            list_idx     <= list_idx_nxt;
        end
    end

    // Result registers, separate from the working list so a new query can
    // open on the beat right after a close without disturbing the emit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out   <= 1'b0;
            sorted_dist <= '1;
            sorted_idx  <= '0;
        end else begin
            valid_out <= emit_nxt;
            if (emit_nxt) begin
                for (int i = 0; i < int'(K); i++) begin
                    sorted_dist[i*DIST_WIDTH +: DIST_WIDTH] <= list_dist_nxt[i];
                    sorted_idx[i*IDX_WIDTH +: IDX_WIDTH]    <= list_idx_nxt[i];
                end
            end
        end
    end

    assign query_open = (state == OPEN);

endmodule

// File: tb/tb_kbest_sorter.sv
// Directed bench for kbest_sorter with K=4: sorting, ties, single beats,
// back-to-back queries, protocol errors and asynchronous reset mid-query.
module tb_kbest_sorter;

    localparam int unsigned DW = 25;
    localparam int unsigned IW = 9;
    localparam int unsigned K  = 4;
    localparam logic [DW-1:0] S = '1;

    logic            clk = 1'b0;
    logic            rst;
    logic            query_valid, query_first_in, query_last_in;
    logic [DW-1:0]   dist_in;
    logic [IW-1:0]   idx_in;
    logic            valid_out;
    logic [K*DW-1:0] sorted_dist;
    logic [K*IW-1:0] sorted_idx;
    logic            query_open;
    logic            protocol_err;

    int checks = 0;
    int errors = 0;

    kbest_sorter #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(K)) dut (
        .clk(clk), .rst(rst),
        .query_valid(query_valid), .query_first_in(query_first_in),
        .query_last_in(query_last_in), .dist_in(dist_in), .idx_in(idx_in),
        .valid_out(valid_out), .sorted_dist(sorted_dist), .sorted_idx(sorted_idx),
        .query_open(query_open), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    function automatic logic [K*DW-1:0] pd(input logic [DW-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [K*IW-1:0] pi(input logic [IW-1:0] i0, i1, i2, i3);
        return {i3, i2, i1, i0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; DUT samples at the next rise.
    task automatic drive(input logic v, f, l, input int d, input int i);
        @(negedge clk);
        query_valid    = v;
        query_first_in = f;
        query_last_in  = l;
        dist_in        = DW'(d);
        idx_in         = IW'(i);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        query_valid = 1'b0; query_first_in = 1'b0; query_last_in = 1'b0;
        dist_in = '0; idx_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(valid_out), 128'(0));
        chk("rst_open", 128'(query_open), 128'(0));
        chk("rst_err", 128'(protocol_err), 128'(0));
        chk("rst_dist", 128'(sorted_dist), 128'(pd(S, S, S, S)));
        chk("rst_idx", 128'(sorted_idx), 128'(0));
        rst = 1'b0;

        // 1: five beats, largest one falls off the end
        drive(1, 1, 0, 50, 1);
        drive(1, 0, 0, 20, 2);
        chk("t1_open", 128'(query_open), 128'(1));
        drive(1, 0, 0, 70, 3);
        drive(1, 0, 0, 10, 4);
        drive(1, 0, 1, 30, 5);
        chk("t1_nopulse_early", 128'(valid_out), 128'(0));
        idle();
        chk("t1_valid", 128'(valid_out), 128'(1));
        chk("t1_dist", 128'(sorted_dist), 128'(pd(10, 20, 30, 50)));
        chk("t1_idx", 128'(sorted_idx), 128'(pi(4, 2, 5, 1)));
        chk("t1_closed", 128'(query_open), 128'(0));
        idle();
        chk("t1_pulse_one", 128'(valid_out), 128'(0));
        chk("t1_hold", 128'(sorted_dist), 128'(pd(10, 20, 30, 50)));

        // 2: ties keep arrival order
        drive(1, 1, 0, 40, 7);
        drive(1, 0, 0, 40, 8);
        drive(1, 0, 1, 40, 9);
        idle();
        chk("t2_valid", 128'(valid_out), 128'(1));
        chk("t2_dist", 128'(sorted_dist), 128'(pd(40, 40, 40, S)));
        chk("t2_idx", 128'(sorted_idx), 128'(pi(7, 8, 9, 0)));

        // 3: single-beat query
        idle();
        drive(1, 1, 1, 15, 3);
        idle();
        chk("t3_valid", 128'(valid_out), 128'(1));
        chk("t3_open", 128'(query_open), 128'(0));
        chk("t3_dist", 128'(sorted_dist), 128'(pd(15, S, S, S)));
        chk("t3_idx", 128'(sorted_idx), 128'(pi(3, 0, 0, 0)));

        // 4: back-to-back queries
        drive(1, 1, 0, 7, 4);
        drive(1, 0, 1, 5, 1);
        drive(1, 1, 0, 9, 2);
        chk("t4a_valid", 128'(valid_out), 128'(1));
        chk("t4a_dist", 128'(sorted_dist), 128'(pd(5, 7, S, S)));
        chk("t4a_idx", 128'(sorted_idx), 128'(pi(1, 4, 0, 0)));
        drive(1, 0, 1, 1, 3);
        chk("t4_gap", 128'(valid_out), 128'(0));
        chk("t4_open", 128'(query_open), 128'(1));
        idle();
        chk("t4b_valid", 128'(valid_out), 128'(1));
        chk("t4b_dist", 128'(sorted_dist), 128'(pd(1, 9, S, S)));
        chk("t4b_idx", 128'(sorted_idx), 128'(pi(3, 2, 0, 0)));
        chk("t4_no_err", 128'(protocol_err), 128'(0));

        // 5: protocol violations
        drive(1, 0, 0, 3, 6);
        idle();
        chk("t5_err_idle", 128'(protocol_err), 128'(1));
        chk("t5_stay_idle", 128'(query_open), 128'(0));
        chk("t5_no_emit", 128'(valid_out), 128'(0));
        drive(1, 1, 0, 60, 1);
        drive(1, 0, 0, 25, 2);
        drive(1, 1, 0, 80, 3);
        drive(1, 0, 1, 45, 4);
        chk("t5_reopen", 128'(query_open), 128'(1));
        idle();
        chk("t5_valid", 128'(valid_out), 128'(1));
        chk("t5_dist", 128'(sorted_dist), 128'(pd(45, 80, S, S)));
        chk("t5_idx", 128'(sorted_idx), 128'(pi(4, 3, 0, 0)));
        chk("t5_sticky", 128'(protocol_err), 128'(1));

        // 6: asynchronous reset mid-query
        drive(1, 1, 0, 11, 1);
        drive(1, 0, 0, 12, 2);
        idle();
        chk("t6_open_pre", 128'(query_open), 128'(1));
        #1 rst = 1'b1;
        #1;
        chk("t6_open", 128'(query_open), 128'(0));
        chk("t6_err", 128'(protocol_err), 128'(0));
        chk("t6_dist", 128'(sorted_dist), 128'(pd(S, S, S, S)));
        chk("t6_idx", 128'(sorted_idx), 128'(0));
        chk("t6_valid", 128'(valid_out), 128'(0));
        #1 rst = 1'b0;
        drive(1, 0, 1, 13, 3);
        idle();
        chk("t6_no_emit", 128'(valid_out), 128'(0));
        chk("t6_err_stray", 128'(protocol_err), 128'(1));
        drive(1, 1, 0, 8, 1);
        drive(1, 0, 1, 2, 2);
        idle();
        chk("t6_post_valid", 128'(valid_out), 128'(1));
        chk("t6_post_dist", 128'(sorted_dist), 128'(pd(2, 8, S, S)));
        chk("t6_post_idx", 128'(sorted_idx), 128'(pi(2, 1, 0, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbest_sorter.md
Name: kbest_sorter

Overview:
- Responder end of the k0 query stream driven by the main search FSM.
- Accepts one candidate (distance, patch index) per cycle, framed by first/last markers. Keeps a running sorted list of the K smallest distances for the open query.
- On the closing beat, presents the K-best list with a one-cycle `valid_out` pulse. This pulse is the `s0_valid_out` consumed by the FSM, and the list is written into the best arrays.

Parameters:
- `DIST_WIDTH`, 25, width of the candidate distance (unsigned).
- `IDX_WIDTH`, 9, width of the candidate index ({leaf index, element-in-leaf}).
- `K`, 4, number of best entries kept and reported.

Ports:
- `clk`  input  1  clock, all state on the rising edge.
- `rst`  input  1  asynchronous active-high reset.
- `query_valid`  input  1  candidate beat valid this cycle.
- `query_first_in`  input  1  beat opens a new query; qualified by `query_valid`.
- `query_last_in`  input  1  beat closes the open query; qualified by `query_valid`.
- `dist_in`  input  DIST_WIDTH  candidate distance.
- `idx_in`  input  IDX_WIDTH  candidate index.
- `valid_out`  output  1  one-cycle pulse: sorted results valid.
- `sorted_dist`  output  K x DIST_WIDTH  ascending distances, entry 0 smallest.
- `sorted_idx`  output  K x IDX_WIDTH  indices matching `sorted_dist`.
- `query_open`  output  1  a query has been opened and not yet closed.
- `protocol_err`  output  1  sticky protocol violation flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - `valid_out`=0, `query_open`=0, `protocol_err`=0.
  - `sorted_dist` all ones, `sorted_idx` all zero.
  - Internal working list: dist all ones, idx zero.
- There is no backpressure. A beat is accepted every cycle `query_valid`=1. `first_in`/`last_in` are ignored when `query_valid`=0.
- State is two-state (IDLE, OPEN), with `query_open` = (state==OPEN).
  - IDLE + valid + first, no last: load working list with the candidate in entry 0 and all ones/zero in entries 1..K-1; go to OPEN.
  - IDLE + valid + first + last: single-candidate query. Load as above and emit results next cycle; stay IDLE.
  - IDLE + valid without first: set `protocol_err`; drop the candidate; list unchanged.
  - OPEN + valid, no first/last: insert the candidate.
  - OPEN + valid + last: insert the candidate, emit, go to IDLE.
  - OPEN + valid + first: set `protocol_err`. Discard the old list and restart with this candidate, exactly as the IDLE+first row. If last is also set, emit next cycle.
- Insertion is a single-cycle parallel compare-and-shift:
  - Position p = number of entries with dist <= `dist_in`.
  - Entries at p and above shift up one; entry K-1 drops. The candidate is written at p.
  - If p==K the candidate is discarded.
  - Ties: the earlier arrival keeps the lower position (the candidate goes after equal entries).
- Emit:
  - The cycle after the closing beat, `valid_out`=1 for exactly one cycle.
  - `sorted_dist`/`sorted_idx` update in the same edge to the post-insertion list and hold until the next emit.
  - Latency from the last beat to `valid_out` is 1 cycle.
- Back-to-back queries: a first beat in the cycle right after a last beat is legal. Emission of the previous query is unaffected because the output registers are separate from the working list.
- Fewer than K candidates: unused entries report dist all ones, idx 0.
- Comparison is unsigned, full `DIST_WIDTH`. No saturation logic; all ones is the sentinel. A real candidate equal to all ones places after any sentinel already in the list, per the tie rule.
- `protocol_err` clears only on reset.
- Reset mid-query: everything returns to reset values immediately. No `valid_out` is produced for the aborted query.

Test Plan:
1. K=4. Beats (dist,idx): first (50,1), (20,2), (70,3), (10,4), last (30,5) -> one cycle after last, `valid_out`=1 for 1 cycle; dist 10,20,30,50; idx 4,2,5,1.
2. Tie: first (40,7), (40,8), last (40,9) -> dist 40,40,40,all ones; idx 7,8,9,0.
3. Single beat with first+last (15,3) -> next cycle `valid_out`=1; dist 15,all ones x3; `query_open` stays 0.
4. Back-to-back: query A ends with last (5,1); next cycle first (9,2) and last (1,3) for query B -> `valid_out` pulses with A = 5,... then, the cycle after B's last, with B = 1,9,...; no cross-contamination.
5. Protocol: valid beat with no first while IDLE, then valid+first while OPEN -> `protocol_err`=1 and stays 1; the IDLE beat is dropped; the second query's results contain only its own candidates.
6. Async reset asserted mid-query after 2 beats -> outputs at reset values within the same cycle; no `valid_out`; a following normal query sorts correctly.
